// File: rtl/multicycle_alu_mem_p_pkg.sv
// rtl/multicycle_alu_mem_p_pkg.sv - opcode/state types and helpers shared by the multi-cycle ALU (flags build: MCALU_FLAGS_EN)
package mcalu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_LOAD  = 3'b101,
    OP_STORE = 3'b110,
    OP_ADDM  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EXECUTE   = 3'd1,
    MEM_READ  = 3'd2,
    MEM_WRITE = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  // Commands that touch the scratch memory rather than going straight to the ALU
  function automatic logic is_mem_op(op_t op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADDM);
  endfunction

endpackage

// File: rtl/multicycle_alu_mem_p_if.sv
// rtl/multicycle_alu_mem_p_if.sv - command/result bundle of the multi-cycle ALU; zero/carry present only with MCALU_FLAGS_EN
interface multicycle_alu_mem_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0]        Op;
  logic [ADDR_W-1:0] Address;
  logic              busy;
  logic [DATA_W:0]   Y;
  logic [DATA_W-1:0] MemOut;
  logic              done;
`ifdef MCALU_FLAGS_EN
  logic              zero;
  logic              carry;

  modport master (
    output start, A, B, Op, Address,
    input  busy, Y, MemOut, done, zero, carry
  );
  modport slave (
    input  start, A, B, Op, Address,
    output busy, Y, MemOut, done, zero, carry
  );
`else
  modport master (
    output start, A, B, Op, Address,
    input  busy, Y, MemOut, done
  );
  modport slave (
    input  start, A, B, Op, Address,
    output busy, Y, MemOut, done
  );
`endif
endinterface

// File: rtl/multicycle_alu_mem_p_alu.sv
// rtl/multicycle_alu_mem_p_alu.sv - combinational ALU; MSB of result is carry for ADD, borrow for SUB
module mcalu_alu
  import mcalu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_t               op,
  output logic [DATA_W:0]   result
);

  // One extra bit on both operands so the top bit carries out / borrows in
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_XOR:  result = {1'b0, a ^ b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu_mem_p.sv
// rtl/multicycle_alu_mem_p.sv - multi-cycle ALU with scratch register file and start/busy/done handshake (MCALU_FLAGS_EN adds zero/carry)
module multicycle_alu_mem_p
  import mcalu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_alu_mem_p_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  logic [DATA_W:0]   y_q, y_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              mem_we;
`ifdef MCALU_FLAGS_EN
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  op_t               start_op;
  op_t               alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_result;

  assign start_op = op_t'(bus.Op);

  // ADDM reuses the adder with the word fetched from memory as second operand
  assign alu_op = (op_q == OP_ADDM) ? OP_ADD : op_q;
  assign alu_b  = (op_q == OP_ADDM) ? tmp_q : b_q;

  mcalu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: route by opcode at acceptance, then a fixed walk back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (start_op == OP_STORE)    state_d = MEM_WRITE;
          else if (is_mem_op(start_op)) state_d = MEM_READ;
          else                          state_d = EXECUTE;
        end
      end
      EXECUTE:   state_d = WRITEBACK;
      MEM_READ:  state_d = (op_q == OP_ADDM) ? EXECUTE : WRITEBACK;
      MEM_WRITE: state_d = IDLE;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; results commit on the edge leaving WRITEBACK/MEM_WRITE
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    addr_d   = addr_q;
    tmp_d    = tmp_q;
    y_d      = y_q;
    memout_d = memout_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    busy_d   = (state_d != IDLE);
`ifdef MCALU_FLAGS_EN
    zero_d   = zero_q;
    carry_d  = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = start_op;
          a_d    = bus.A;
          b_d    = bus.B;
          addr_d = bus.Address;
        end
      end
      MEM_READ: tmp_d = mem[addr_q];
      MEM_WRITE: begin
        mem_we = 1'b1;
        done_d = 1'b1;
      end
      WRITEBACK: begin
        done_d = 1'b1;
        if (op_q == OP_LOAD) begin
          memout_d = tmp_q;
        end else begin
          y_d = alu_result;
`ifdef MCALU_FLAGS_EN
          zero_d  = (alu_result[DATA_W-1:0] == '0);
          carry_d = alu_result[DATA_W];
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      tmp_q    <= '0;
      y_q      <= '0;
      memout_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MCALU_FLAGS_EN
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`endif
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      tmp_q    <= tmp_d;
      y_q      <= y_d;
      memout_q <= memout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef MCALU_FLAGS_EN
      zero_q   <= zero_d;
      carry_q  <= carry_d;
`endif
    end
  end

  // Scratch memory is not reset; a reset before the MEM_WRITE edge drops the store
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= a_q;
  end

  assign bus.busy   = busy_q;
  assign bus.Y      = y_q;
  assign bus.MemOut = memout_q;
  assign bus.done   = done_q;
`ifdef MCALU_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
`endif

endmodule

// File: doc/multicycle_alu_mem_p.md
Name: multicycle_alu_mem_p

Overview:
Parametrised multi-cycle ALU with an internal register-file memory and a start/busy/done handshake.
- Widens the 2-bit/16-entry datapath to DATA_W/ADDR_W.
- Latches operands at start.
- Adds XOR, a memory-operand ADD (ADDM) and a done pulse for every operation, including STORE.
- Sits beside the sequencer as a shared compute/scratch unit, driven one command at a time.

Parameters:
DATA_W, 8, operand and memory word width (>=2)
ADDR_W, 4, memory address width; depth = 2**ADDR_W

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  command request; sampled only in IDLE
A  in  DATA_W  operand A / store data
B  in  DATA_W  operand B
Op  in  3  opcode (see Behaviour)
Address  in  ADDR_W  memory address for LOAD/STORE/ADDM
busy  out  1  high whenever FSM is not IDLE
Y  out  DATA_W+1  ALU result; MSB = carry/borrow
MemOut  out  DATA_W  last LOAD data
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: asynchronous assert on reset_n=0, synchronous release. FSM to IDLE; Y, MemOut, done, busy and the operand latches go to 0. Memory contents are not reset.
- Reset mid-operation aborts the command with no done. A STORE whose MEM_WRITE edge has not occurred leaves memory unchanged.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LOAD, 110 STORE, 111 ADDM.
- ADD: Y = zero-extended A + B.
- SUB: Y = (DATA_W+1)-bit A - B, so the MSB is the borrow. Example: 3 - 5 at W=8 gives 0x1FE.
- AND/OR/XOR: Y[W-1:0] = result, Y[W] = 0.
- ADDM: Y = A + Mem[Address], zero-extended.
- Acceptance: in IDLE with start=1 at edge k, the block latches A, B, Op and Address and leaves IDLE. Inputs may change afterwards.
- start outside IDLE is ignored; there is no queue.
- FSM states: IDLE, EXECUTE, MEM_READ, MEM_WRITE, WRITEBACK.
- IDLE -> EXECUTE for Op 0xx and 100.
- IDLE -> MEM_READ for LOAD and ADDM.
- IDLE -> MEM_WRITE for STORE.
- EXECUTE -> WRITEBACK.
- MEM_READ -> WRITEBACK for LOAD; MEM_READ -> EXECUTE for ADDM. The read word is held in a temp register.
- MEM_WRITE -> IDLE; Mem[Address] <= A at that edge.
- WRITEBACK -> IDLE.
- done and the result registers update on the edge leaving WRITEBACK (or MEM_WRITE). done is high for exactly one cycle, while the FSM is back in IDLE.
- Latency, counted as edges after edge k until done is high: ALU ops 2, LOAD 2, ADDM 3, STORE 1.
- Outputs per op: Y updates only for ALU ops and ADDM. MemOut updates only for LOAD. STORE leaves Y and MemOut unchanged.
- Back-to-back: start high in the cycle done is high is accepted at that edge, with no bubble.
- A LOAD from an address stored by the immediately preceding command returns the new data.
- Address wraps naturally at 2**ADDR_W; there are no out-of-range addresses.
- A LOAD from a never-written address returns X in simulation; the bench must not depend on it.
- busy = (state != IDLE), registered consistently with the state.

Optional Feature:
Macro: MCALU_FLAGS_EN.
- Defined: adds output ports zero (1) and carry (1), both updated together with Y.
  - zero = (Y[W-1:0] == 0).
  - carry = Y[W].
  - Both reset to 0 and hold through LOAD and STORE.
- Undefined: the ports and their logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package mcalu_pkg holds:
  - op_t enum (3-bit encodings above);
  - state_t enum (3-bit: IDLE=0, EXECUTE=1, MEM_READ=2, MEM_WRITE=3, WRITEBACK=4);
  - function is_mem_op(op_t).
- Sub-module mcalu_alu: combinational, parametrised by DATA_W. Inputs a, b, op; output DATA_W+1 result. Instantiated once; ADDM drives it with b = memory temp and op = ADD.
- Memory array and FSM stay in the top level.

Test Plan:
- DATA_W=8: reset, then ADD A=0xFF B=0x01 -> done 2 edges after accept, Y=0x100, busy high for 2 cycles; with flags: carry=1, zero=1.
- SUB A=3 B=5 -> Y=0x1FE. Then XOR A=0xA5 B=0x5A -> Y=0x0FF.
- STORE A=0x3C Addr=9 -> done after 1 edge, Y unchanged. Then LOAD Addr=9 issued in the done cycle -> MemOut=0x3C after 2 edges.
- ADDM A=0x10 Addr=9 (Mem=0x3C) -> Y=0x04C, done 3 edges after accept. A start pulsed during busy is ignored (no extra done).
- Change A/B/Op the cycle after accept -> result reflects the latched values.
- Reset mid-op: reset_n low during MEM_READ of a LOAD -> no done, all outputs 0. Reset_n low on a STORE before its MEM_WRITE edge -> a later LOAD shows the old data.
